// File: rtl/lcd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_pkg                                                               |
// | Shared types and defaults for the LCD frame read path.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package lcd_pkg;

  localparam int c_H_ACTIVE    = 480;
  localparam int c_V_ACTIVE    = 272;
  localparam int c_FRAME_WORDS = c_H_ACTIVE * c_V_ACTIVE;
  localparam int c_OFF_W       = 20;
  localparam int c_LEN_W       = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_CHECK     = 3'd2,
    ST_REQ       = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  function automatic logic [c_OFF_W-1:0] frame_words(input int h, input int v);
    return c_OFF_W'(h * v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | lcd_frame_reader                                                      |
// | Vsync-paced SDRAM burst read scheduler feeding the LCD pixel FIFO.    |
// | Optional double buffering when LCD_DBUF_EN is defined.                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module lcd_frame_reader
  import lcd_pkg::*;
#(
  parameter int                H_ACTIVE     = c_H_ACTIVE,
  parameter int                V_ACTIVE     = c_V_ACTIVE,
  parameter int                BURST_LEN    = 256,
  parameter int                FIFO_DEPTH   = 1024,
  parameter int                FIFO_AW      = 10,
  parameter int                ADDR_W       = 22,
  parameter logic [ADDR_W-1:0] FRAME_BASE   = '0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = 'h20000,
  parameter logic              VS_POL       = 1'b0
) (
  input  logic               rgb_clk,
  input  logic               rgb_rst,
  input  logic               rgb_vs,
  input  logic               rgb_de,
  input  logic [FIFO_AW:0]   fifo_level,
  output logic               fifo_clr,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [8:0]         rd_len,
  input  logic               rd_ack,
  input  logic               rd_done,
  output logic               frame_start,
  output logic               underflow
`ifdef LCD_DBUF_EN
  ,
  input  logic               wr_frame_done,
  input  logic               wr_bank,
  output logic               rd_bank
`endif
);

  localparam logic [c_OFF_W-1:0] c_FRAME = frame_words(H_ACTIVE, V_ACTIVE);
  localparam logic [c_OFF_W-1:0] c_BURST = c_OFF_W'(BURST_LEN);
  localparam logic [FIFO_AW:0]   c_ROOM  = (FIFO_AW+1)'(FIFO_DEPTH - BURST_LEN);

  state_t               r_state;
  logic                 r_vs_d;
  logic                 r_pend;
  logic [c_OFF_W-1:0]   r_offset;
  logic                 r_fifo_clr;
  logic                 r_rd_req;
  logic [ADDR_W-1:0]    r_rd_addr;
  logic [c_LEN_W-1:0]   r_rd_len;
  logic                 r_underflow;

  logic                 w_vs_start;
  logic                 w_bank;
  logic [ADDR_W-1:0]    w_base;
  logic [c_OFF_W-1:0]   w_remain;
  logic [c_LEN_W-1:0]   w_len;

  assign w_vs_start = (rgb_vs == VS_POL) && (r_vs_d != VS_POL);
  assign w_remain   = c_FRAME - r_offset;
  // Final burst of the frame is truncated so nothing past the frame is fetched
  assign w_len      = (w_remain >= c_BURST) ? c_BURST[c_LEN_W-1:0] : w_remain[c_LEN_W-1:0];
  assign w_base     = w_bank ? (FRAME_BASE + FRAME_STRIDE) : FRAME_BASE;

`ifdef LCD_DBUF_EN
  logic r_wr_last;
  logic r_bank;

  // Display bank switches only at frame restart, never mid-frame
  always_ff @(posedge rgb_clk) begin
    if (rgb_rst) begin
      r_wr_last <= 1'b0;
      r_bank    <= 1'b0;
    end else begin
      if (wr_frame_done) r_wr_last <= wr_bank;
      if (r_state == ST_FLUSH) r_bank <= r_wr_last;
    end
  end

  assign w_bank  = r_bank;
  assign rd_bank = r_bank;
`else
  assign w_bank  = 1'b0;
`endif

  always_ff @(posedge rgb_clk) begin
    if (rgb_rst) begin
      r_state     <= ST_IDLE;
      r_vs_d      <= ~VS_POL;
      r_pend      <= 1'b0;
      r_offset    <= '0;
      r_fifo_clr  <= 1'b0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= FRAME_BASE;
      r_rd_len    <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_vs_d     <= rgb_vs;
      r_fifo_clr <= 1'b0;

      if (r_state == ST_FLUSH)
        r_underflow <= 1'b0;
      else if (rgb_de && (fifo_level == '0))
        r_underflow <= 1'b1;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_vs_start) begin
            r_state    <= ST_FLUSH;
            r_fifo_clr <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_offset <= '0;
          r_pend   <= 1'b0;
          r_state  <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_vs_start) begin
            r_state    <= ST_FLUSH;
            r_fifo_clr <= 1'b1;
          end else if (w_remain == '0) begin
            r_state <= ST_DONE;
          end else if (fifo_level <= c_ROOM) begin
            r_state   <= ST_REQ;
            r_rd_req  <= 1'b1;
            r_rd_addr <= w_base + ADDR_W'(r_offset);
            r_rd_len  <= w_len;
          end
        end
        ST_REQ: begin
          // An ack in the same cycle as vsync still owns the burst
          if (rd_ack) begin
            r_rd_req <= 1'b0;
            r_pend   <= w_vs_start;
            r_state  <= ST_WAIT_DONE;
          end else if (w_vs_start) begin
            r_rd_req   <= 1'b0;
            r_state    <= ST_FLUSH;
            r_fifo_clr <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (rd_done) begin
            r_offset <= r_offset + c_OFF_W'(r_rd_len);
            if (r_pend || w_vs_start) begin
              r_state    <= ST_FLUSH;
              r_fifo_clr <= 1'b1;
            end else begin
              r_state <= ST_CHECK;
            end
          end else if (w_vs_start) begin
            r_pend <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_clr    = r_fifo_clr;
  assign frame_start = r_fifo_clr;
  assign rd_req      = r_rd_req;
  assign rd_addr     = r_rd_addr;
  assign rd_len      = r_rd_len;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_lcd_frame_reader                                                   |
// | Directed bench with frame-level reference model for lcd_frame_reader. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_lcd_frame_reader;

  localparam int FAW   = 4;
  localparam int FRAME = 32;
  localparam int BURST = 4;

  logic clk = 1'b0, rst = 1'b1, vs = 1'b1, de = 1'b0, ack = 1'b0, done = 1'b0;
  logic [FAW:0] lvl = '0;
  logic fifo_clr, rd_req, frame_start, underflow;
  logic [21:0] rd_addr;
  logic [8:0]  rd_len;

  logic ack_b = 1'b0, done_b = 1'b0;
  logic [FAW:0] lvl_b = '0;
  logic fifo_clr_b, rd_req_b, frame_start_b, underflow_b;
  logic [21:0] rd_addr_b;
  logic [8:0]  rd_len_b;

`ifdef LCD_DBUF_EN
  logic wr_done = 1'b0, wr_bank = 1'b0, rd_bank, rd_bank_b;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_frame_reader #(.H_ACTIVE(8), .V_ACTIVE(4), .BURST_LEN(4), .FIFO_DEPTH(16), .FIFO_AW(4)) u_dut (
    .rgb_clk(clk), .rgb_rst(rst), .rgb_vs(vs), .rgb_de(de), .fifo_level(lvl),
    .fifo_clr(fifo_clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(ack), .rd_done(done), .frame_start(frame_start), .underflow(underflow)
`ifdef LCD_DBUF_EN
    , .wr_frame_done(wr_done), .wr_bank(wr_bank), .rd_bank(rd_bank)
`endif
  );

  lcd_frame_reader #(.H_ACTIVE(6), .V_ACTIVE(3), .BURST_LEN(4), .FIFO_DEPTH(16), .FIFO_AW(4)) u_dut_b (
    .rgb_clk(clk), .rgb_rst(rst), .rgb_vs(vs), .rgb_de(de), .fifo_level(lvl_b),
    .fifo_clr(fifo_clr_b), .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_len(rd_len_b),
    .rd_ack(ack_b), .rd_done(done_b), .frame_start(frame_start_b), .underflow(underflow_b)
`ifdef LCD_DBUF_EN
    , .wr_frame_done(1'b0), .wr_bank(1'b0), .rd_bank(rd_bank_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_len(input int off);
    return (FRAME - off < BURST) ? FRAME - off : BURST;
  endfunction

  // Frame-level model: restart happens the cycle after vsync unless a burst
  // is in flight, in which case it follows that burst's completion.
  logic m_vs_d, m_flush, m_pend, m_out, m_uf;
  int m_off;
  logic m_vs_st, m_busy;
  logic [31:0] m_base;

  assign m_vs_st = !vs && m_vs_d;
  assign m_busy  = (m_out && !done) || ack;

  always @(posedge clk) begin
    if (rst) begin
      m_vs_d <= 1'b1; m_flush <= 1'b0; m_pend <= 1'b0; m_out <= 1'b0; m_uf <= 1'b0; m_off <= 0;
    end else begin
      m_vs_d  <= vs;
      m_flush <= 1'b0;
      if ((m_vs_st || m_pend) && !m_busy) begin
        m_flush <= 1'b1;
        m_pend  <= 1'b0;
      end else if (m_vs_st) begin
        m_pend <= 1'b1;
      end
      if (ack) m_out <= 1'b1;
      else if (done) m_out <= 1'b0;
      if (m_flush) m_uf <= 1'b0;
      else if (de && lvl == 0) m_uf <= 1'b1;
      if (m_flush) m_off <= 0;
      else if (done) m_off <= m_off + exp_len(m_off);
    end
  end

`ifdef LCD_DBUF_EN
  logic m_wr, m_bank;
  always @(posedge clk) begin
    if (rst) begin
      m_wr <= 1'b0; m_bank <= 1'b0;
    end else begin
      if (wr_done) m_wr <= wr_bank;
      if (m_flush) m_bank <= m_wr;
    end
  end
  assign m_base = m_bank ? 32'h20000 : 32'h0;
`else
  assign m_base = 32'h0;
`endif

  always @(negedge clk) begin
    if (!rst) begin
      chk("fifo_clr", {31'b0, fifo_clr}, {31'b0, m_flush});
      chk("frame_start", {31'b0, frame_start}, {31'b0, m_flush});
      chk("underflow", {31'b0, underflow}, {31'b0, m_uf});
      if (m_flush) chk("req_in_flush", {31'b0, rd_req}, 32'd0);
      if (rd_req) begin
        chk("req_addr", {10'b0, rd_addr}, m_base + m_off);
        chk("req_len", {23'b0, rd_len}, exp_len(m_off));
      end
    end
  end

  // Autonomous arbiter for the 6x3 instance; logs each accepted burst.
  int qa[$];
  int ql[$];
  logic b_busy = 1'b0;
  int b_cnt = 0;
  initial forever begin
    tick();
    ack_b = 1'b0;
    done_b = 1'b0;
    if (rst) begin
      b_busy = 1'b0;
    end else if (rd_req_b && !b_busy) begin
      ack_b = 1'b1; b_busy = 1'b1; b_cnt = 2;
      qa.push_back(int'(rd_addr_b));
      ql.push_back(int'(rd_len_b));
    end else if (b_busy) begin
      if (b_cnt == 0) begin
        done_b = 1'b1; b_busy = 1'b0;
      end else begin
        b_cnt--;
      end
    end
  end

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!rd_req && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, rd_req}, 32'd1);
  endtask

  int n;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_req", {31'b0, rd_req}, 32'd0);
    chk("rst_addr", {10'b0, rd_addr}, 32'd0);
    chk("rst_len", {23'b0, rd_len}, 32'd0);
    chk("rst_clr", {31'b0, fifo_clr}, 32'd0);
    chk("rst_fs", {31'b0, frame_start}, 32'd0);
    chk("rst_uf", {31'b0, underflow}, 32'd0);

    // vsync edge: clear pulse, then first request two cycles later
    vs = 1'b0;
    tick();
    chk("t1_clr", {31'b0, fifo_clr}, 32'd1);
    chk("t1_fs", {31'b0, frame_start}, 32'd1);
    tick();
    vs = 1'b1;
    chk("t1_clr_one_cycle", {31'b0, fifo_clr}, 32'd0);
    chk("t1_no_req_yet", {31'b0, rd_req}, 32'd0);
    tick();
    chk("t1_req", {31'b0, rd_req}, 32'd1);
    chk("t1_addr", {10'b0, rd_addr}, 32'd0);
    chk("t1_len", {23'b0, rd_len}, 32'd4);

    // whole 8x4 frame in 8 bursts
    for (int k = 0; k < 8; k++) begin
      wait_req("t2_req_timeout");
      chk("t2_addr", {10'b0, rd_addr}, 32'(4 * k));
      chk("t2_len", {23'b0, rd_len}, 32'd4);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t2_req_drop", {31'b0, rd_req}, 32'd0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    n = 0;
    repeat (10) begin
      tick();
      n += int'(rd_req);
    end
    chk("t2_no_req_after_frame", n, 32'd0);

    // 6x3 instance: truncated last burst
    chk("b_count", qa.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < qa.size()) begin
        chk("b_addr", qa[i], 32'(4 * i));
        chk("b_len", ql[i], (i == 4) ? 32'd2 : 32'd4);
      end
    end

    // FIFO too full: no request until level drops to 12
    lvl = 5'd13;
    vs = 1'b0;
    tick();
    vs = 1'b1;
    chk("t3_clr", {31'b0, fifo_clr}, 32'd1);
    n = 0;
    repeat (6) begin
      tick();
      n += int'(rd_req);
    end
    chk("t3_full_no_req", n, 32'd0);
    lvl = 5'd12;
    tick();
    chk("t3_req_when_room", {31'b0, rd_req}, 32'd1);
    chk("t3_addr", {10'b0, rd_addr}, 32'd0);

    // vsync while a burst is in flight: restart deferred until rd_done
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t5_req_drop", {31'b0, rd_req}, 32'd0);
    vs = 1'b0;
    tick();
    vs = 1'b1;
    n = 0;
    repeat (4) begin
      chk("t5_no_clr_in_wait", {31'b0, fifo_clr}, 32'd0);
      tick();
      n += int'(rd_req);
    end
    chk("t5_wait_quiet", n, 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t5_flush_after_done", {31'b0, fifo_clr}, 32'd1);
    tick();
    tick();
    chk("t5_req", {31'b0, rd_req}, 32'd1);
    chk("t5_addr_rewound", {10'b0, rd_addr}, 32'd0);

    // underflow: sticky until the next frame restart
    lvl = '0;
    de = 1'b1;
    tick();
    de = 1'b0;
    tick();
    chk("t6_uf_set", {31'b0, underflow}, 32'd1);
    repeat (3) tick();
    chk("t6_uf_sticky", {31'b0, underflow}, 32'd1);
`ifdef LCD_DBUF_EN
    wr_bank = 1'b1;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    wr_bank = 1'b0;
`endif
    vs = 1'b0;
    tick();
    vs = 1'b1;
    chk("t6_clr", {31'b0, fifo_clr}, 32'd1);
    chk("t6_uf_in_flush", {31'b0, underflow}, 32'd1);
    tick();
    chk("t6_uf_cleared", {31'b0, underflow}, 32'd0);
    tick();
    chk("t6_req", {31'b0, rd_req}, 32'd1);
`ifdef LCD_DBUF_EN
    chk("t6_bank1_addr", {10'b0, rd_addr}, 32'h20000);
`else
    chk("t6_addr", {10'b0, rd_addr}, 32'd0);
`endif
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
